// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch stage with a DEPTH-entry prefetch queue.
// Owns the PC, issues reads to a one-cycle-latency instruction memory, and
// buffers {instr, pc} pairs for decode behind a valid/ready handshake.
// Taken branches and reset flush the queue and any in-flight read.
module if_prefetch #(
  parameter int ARQ              = 16,
  parameter int MEMORY_ADDR_SIZE = 6,
  parameter int DEPTH            = 4,
  parameter logic [MEMORY_ADDR_SIZE-1:0] RESET_ADDR = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_en,
  input  logic                          branch_en,
  input  logic [MEMORY_ADDR_SIZE-1:0]   branch_addr,
  output logic                          mem_rd,
  output logic [MEMORY_ADDR_SIZE-1:0]   mem_addr,
  input  logic [ARQ-1:0]                mem_data,
  output logic [ARQ-1:0]                instr,
  output logic [MEMORY_ADDR_SIZE-1:0]   instr_pc,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [$clog2(DEPTH):0]        fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [MEMORY_ADDR_SIZE-1:0] fetch_pc;
  logic                        inflight;
  logic [MEMORY_ADDR_SIZE-1:0] inflight_tag;
  logic [PW-1:0]               rd_ptr;
  logic [PW-1:0]               wr_ptr;
  logic [CW-1:0]               count;

  logic [ARQ-1:0]              fifo_instr [DEPTH];
  logic [MEMORY_ADDR_SIZE-1:0] fifo_pc    [DEPTH];

  logic [CW:0] occupancy;
  logic        credit_ok;
  logic        issue;
  logic        push;
  logic        pop;

  // A read is only issued when the queue is guaranteed a free slot for it,
  // counting the word still in flight, so the FIFO can never overflow.
  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    credit_ok = occupancy < DEPTH_W;
    issue     = fetch_en & ~branch_en & ~rst & credit_ok;
    push      = inflight & ~branch_en & ~rst;
    pop       = (count != '0) & instr_ready & ~branch_en & ~rst;
  end

  assign mem_rd      = issue;
  assign mem_addr    = fetch_pc;
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign instr_valid = (count != '0);
  assign fifo_count  = count;

  // PC, in-flight tracking and queue bookkeeping; reset and branch both flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc     <= RESET_ADDR;
      inflight     <= 1'b0;
      inflight_tag <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else if (branch_en) begin
      fetch_pc <= branch_addr;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc     <= fetch_pc + MEMORY_ADDR_SIZE'(1);
        inflight_tag <= fetch_pc;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage: the returning word is stored with the PC that fetched it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= mem_data;
      fifo_pc[wr_ptr]    <= inflight_tag;
    end
  end

endmodule
